// File: rtl/wshbn_master_line_xfer_pkg.sv
// Shared constants, state encoding and address helper for the Wishbone cache-line master.
package wshbn_master_line_xfer_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int WORD_WIDTH = 32;
    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } wshbn_master_st_t;

    // First word address of the line containing addr (low idx_w bits cleared).
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr,
                                                        input int idx_w);
        return addr & ~ADDR_WIDTH'((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/wshbn_master_line_xfer_if.sv
// Wishbone classic bus between the line-transfer master and the data RAM slave.
interface wshbn_master_line_xfer_if;
    import wshbn_master_line_xfer_pkg::*;

    logic [ADDR_WIDTH-1:0] ADR_O;
    logic [WORD_WIDTH-1:0] DAT_O;
    logic [WORD_WIDTH-1:0] DAT_I;
    logic                  WE_O;
    logic                  STB_O;
    logic                  CYC_O;
    logic                  ACK_I;

    modport master (
        output ADR_O, DAT_O, WE_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        input  ADR_O, DAT_O, WE_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );

endinterface

// File: rtl/wshbn_master_line_xfer.sv
// Wishbone master moving one cache line (refill or write-back) as a single held-CYC burst.
// Optional ACK watchdog enabled by defining WSHBN_TIMEOUT_EN.
module wshbn_master_line_xfer
    import wshbn_master_line_xfer_pkg::*;
#(
    parameter int LINE_WORDS = wshbn_master_line_xfer_pkg::LINE_WORDS,
    parameter int IDX_W      = $clog2(LINE_WORDS)
`ifdef WSHBN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                             CLK_I,
    input  logic                             RST_I,
    input  logic                             req_i,
    input  logic                             req_we_i,
    input  logic [ADDR_WIDTH-1:0]            req_addr_i,
    input  logic [LINE_WORDS*WORD_WIDTH-1:0] wr_line_i,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] rd_line_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o,
    wshbn_master_line_xfer_if.master         wb
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    wshbn_master_st_t                 state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [IDX_W-1:0]                 idx_inc;
    logic [ADDR_WIDTH-IDX_W-1:0]      line_q, line_d;
    logic                             mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]            adr_q, adr_d;
    logic [WORD_WIDTH-1:0]            dat_q, dat_d;
    logic                             we_q, we_d;
    logic                             stb_q, stb_d;
    logic                             cyc_q, cyc_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [WORD_WIDTH-1:0]            req_word  [LINE_WORDS];
    logic [WORD_WIDTH-1:0]            wr_word_q [LINE_WORDS];
    logic [WORD_WIDTH-1:0]            wr_word_d [LINE_WORDS];
    logic [WORD_WIDTH-1:0]            rd_word_q [LINE_WORDS];
    logic [WORD_WIDTH-1:0]            rd_word_d [LINE_WORDS];

`ifdef WSHBN_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              timeout;

    // Last no-ACK cycle allowed; the abort edge is TIMEOUT_CYCLES edges after STB rises.
    assign timeout = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
            assign req_word[gi]                            = wr_line_i[gi*WORD_WIDTH +: WORD_WIDTH];
            assign rd_line_o[gi*WORD_WIDTH +: WORD_WIDTH] = rd_word_q[gi];
        end
    endgenerate

    assign wb.ADR_O = adr_q;
    assign wb.DAT_O = dat_q;
    assign wb.WE_O  = we_q;
    assign wb.STB_O = stb_q;
    assign wb.CYC_O = cyc_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        line_d    = line_q;
        mode_d    = mode_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        stb_d     = stb_q;
        cyc_d     = cyc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_word_d = wr_word_q;
        rd_word_d = rd_word_q;
        idx_inc   = idx_q + IDX_W'(1);
`ifdef WSHBN_TIMEOUT_EN
        wait_d    = wait_q;
        err_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d   = BURST;
                    idx_d     = '0;
                    line_d    = req_addr_i[ADDR_WIDTH-1:IDX_W];
                    mode_d    = req_we_i;
                    wr_word_d = req_word;
                    adr_d     = line_base(req_addr_i, IDX_W);
                    dat_d     = req_we_i ? req_word[0] : '0;
                    we_d      = req_we_i;
                    stb_d     = 1'b1;
                    cyc_d     = 1'b1;
                    busy_d    = 1'b1;
`ifdef WSHBN_TIMEOUT_EN
                    wait_d    = '0;
`endif
                end
            end

            BURST: begin
                if (wb.ACK_I) begin
`ifdef WSHBN_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (!mode_q) begin
                        rd_word_d[idx_q] = wb.DAT_I;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        we_d    = 1'b0;
                        stb_d   = 1'b0;
                        cyc_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Offset only replaces the low bits, so the burst wraps inside its line.
                        idx_d = idx_inc;
                        adr_d = {line_q, idx_inc};
                        dat_d = mode_q ? wr_word_q[idx_inc] : '0;
                    end
                end
`ifdef WSHBN_TIMEOUT_EN
                else if (timeout) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            mode_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                wr_word_q[i] <= '0;
                rd_word_q[i] <= '0;
            end
`ifdef WSHBN_TIMEOUT_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            mode_q    <= mode_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_word_q <= wr_word_d;
            rd_word_q <= rd_word_d;
`ifdef WSHBN_TIMEOUT_EN
            wait_q    <= wait_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wshbn_master_line_xfer.sv
// Directed bench for wshbn_master_line_xfer: Wishbone RAM slave model plus bus-transaction scoreboard.
module tb_wshbn_master_line_xfer;
    import wshbn_master_line_xfer_pkg::*;

    localparam int LW = LINE_WORDS;
    localparam int LB = LW * WORD_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [WORD_WIDTH-1:0] data;
    } xfer_t;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  req      = 1'b0;
    logic                  req_we   = 1'b0;
    logic [ADDR_WIDTH-1:0] req_addr = '0;
    logic [LB-1:0]         wr_line  = '0;
    logic [LB-1:0]         rd_line;
    logic                  busy, done, err;

    wshbn_master_line_xfer_if wb ();

    wshbn_master_line_xfer dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .req_i      (req),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .wr_line_i  (wr_line),
        .rd_line_o  (rd_line),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    // Slave: combinational ACK gated by ack_en, which changes shortly after each rising edge.
    logic [WORD_WIDTH-1:0] ram [256];
    int   ack_mode = 0;
    logic ack_en   = 1'b1;

    assign wb.DAT_I = ram[wb.ADR_O[7:0]];
    assign wb.ACK_I = wb.CYC_O & wb.STB_O & ack_en;

    always @(posedge clk) begin
        if (wb.CYC_O && wb.STB_O && wb.ACK_I && wb.WE_O) ram[wb.ADR_O[7:0]] = wb.DAT_O;
        #2;
        case (ack_mode)
            0:       ack_en = 1'b1;
            1:       ack_en = ~ack_en;
            default: ack_en = 1'b0;
        endcase
    end

    xfer_t exp_q[$];
    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc_cnt = 0, last_ack_cyc = 0, done_cnt = 0, err_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobed cycle is compared with the head of the scoreboard, popped on ACK.
    always @(negedge clk) begin
        xfer_t e;
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (wb.CYC_O || busy) begin
            check("cyc_vs_busy", wb.CYC_O, busy);
            check("stb_vs_cyc", wb.STB_O, wb.CYC_O);
        end
        if (wb.CYC_O && wb.STB_O) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cycle", wb.CYC_O, 0);
            end else begin
                e = exp_q[0];
                check(wb.ACK_I ? "adr_ack" : "adr_hold", wb.ADR_O, e.addr);
                check("we_o", wb.WE_O, e.we);
                if (e.we) check("dat_o", wb.DAT_O, e.data);
                if (wb.ACK_I) begin
                    void'(exp_q.pop_front());
                    last_ack_cyc = cyc_cnt;
                end
            end
        end
    end

    task automatic push_expect(input logic [ADDR_WIDTH-1:0] addr, input logic we, input logic [LB-1:0] line);
        xfer_t e;
        logic [ADDR_WIDTH-1:0] base;
        base = addr & ~ADDR_WIDTH'(LW - 1);
        for (int k = 0; k < LW; k++) begin
            e.addr = base + ADDR_WIDTH'(k);
            e.we   = we;
            e.data = we ? line[k*WORD_WIDTH +: WORD_WIDTH] : '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_req(input logic [ADDR_WIDTH-1:0] addr, input logic we, input logic [LB-1:0] line,
                           input bit poke);
        int c;
        int d0;
        d0 = done_cnt;
        push_expect(addr, we, line);
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = addr; wr_line = line;
        @(negedge clk);
        req = 1'b0; wr_line = '0;
        c = 0;
        while (!done && !err && c < 200) begin
            req = poke && (c == 2);
            if (req) begin req_addr = 16'h0090; req_we = 1'b1; end
            @(negedge clk);
            c++;
        end
        req = 1'b0;
        if (!done) begin
            check("done_seen", done, 1);
            return;
        end
        check("done_latency", cyc_cnt, last_ack_cyc + 1);
        check("busy_at_done", busy, 0);
        // A request presented while in DONE must be dropped.
        req = poke; req_addr = 16'h0090; req_we = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("done_width", done, 0);
        @(negedge clk);
        check("idle_after_done", wb.CYC_O, 0);
        check("sb_drained", exp_q.size(), 0);
        check("done_once", done_cnt - d0, 1);
    endtask

    logic [LB-1:0] line_a, line_wb, line_rnd, saved;
    int n_ack, d_before, rise, c;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_a  = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        line_wb = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD_0000 | i;
        for (int k = 0; k < LW; k++) ram[8'h40 + k] = 32'h0000_00A0 + k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_adr", wb.ADR_O, 0);
        check("rst_dat", wb.DAT_O, 0);
        check("rst_we", wb.WE_O, 0);
        check("rst_stb", wb.STB_O, 0);
        check("rst_cyc", wb.CYC_O, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_line", rd_line, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: refill
        run_req(16'h0040, 1'b0, '0, 1'b0);
        check("t1_rd_line", rd_line, line_a);
        $display("refill 0x40 -> rd_line %0h", rd_line);

        // 2: write-back, rd_line must hold, then read back
        run_req(16'h0080, 1'b1, line_wb, 1'b0);
        check("t2_rd_line_hold", rd_line, line_a);
        run_req(16'h0080, 1'b0, '0, 1'b0);
        check("t2_readback", rd_line, line_wb);
        $display("write-back 0x80 readback -> %0h", rd_line);

        // 3: unaligned request maps onto its line base
        run_req(16'h0043, 1'b0, '0, 1'b0);
        check("t3_rd_line", rd_line, line_a);
        $display("refill 0x43 -> rd_line %0h", rd_line);

        // 4: slave acks every other cycle; stray requests mid-burst and in DONE
        ack_mode = 1;
        line_rnd = {$urandom, $urandom, $urandom, $urandom};
        run_req(16'h0026, 1'b1, line_rnd, 1'b1);
        run_req(16'h0024, 1'b0, '0, 1'b1);
        check("t4_rd_line", rd_line, line_rnd);
        $display("slow-ack write/refill 0x24 -> rd_line %0h", rd_line);
        ack_mode = 0;

        // 5: reset after the 2nd ACK of a refill
        saved = rd_line;
        push_expect(16'h0040, 1'b0, '0);
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
        @(negedge clk);
        req = 1'b0;
        n_ack = 0;
        c = 0;
        while (n_ack < 2 && c < 50) begin
            if (wb.CYC_O && wb.STB_O && wb.ACK_I) n_ack++;
            if (n_ack < 2) @(negedge clk);
            c++;
        end
        check("t5_two_acks", n_ack, 2);
        d_before = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_cyc", wb.CYC_O, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_rd_line_cleared", rd_line, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d_before, 0);
        run_req(16'h0041, 1'b0, '0, 1'b0);
        check("t5_fresh_rd_line", rd_line, line_a);
        $display("reset mid-burst then refill 0x41 -> rd_line %0h (was %0h)", rd_line, saved);

`ifdef WSHBN_TIMEOUT_EN
        // 6: slave never acks
        ack_mode = 2;
        d_before = done_cnt;
        push_expect(16'h0060, 1'b0, '0);
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 16'h0060;
        @(negedge clk);
        req = 1'b0;
        rise = cyc_cnt;
        c = 0;
        while (!err && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t6_err_delay", cyc_cnt - rise, 16);
        check("t6_cyc", wb.CYC_O, 0);
        check("t6_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        check("t6_err_width", err, 0);
        check("t6_no_done", done_cnt - d_before, 0);
        check("t6_err_count", err_cnt, 1);
        $display("timeout abort after %0d cycles", c + 1);
        ack_mode = 0;
`else
        check("err_never", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
